mic_capture_ctrl: RTL
=====================

# mic_capture_ctrl

Capture sequencer for the I2S microphone front end in the keyword-spotting pipeline. Calibrates the microphone DC offset and feeds the DC value and level threshold back to the I2S receiver. Watches the receiver's voice-activity flag and records fixed-length, DC-removed frames into a two-bank sample buffer, handing each full bank to the downstream feature/NN engine with a ready/ack handshake.

## Interface
- CAL_LOG2, 8: DC calibration averages 2^CAL_LOG2 samples.
- FRAME_AW, 9: frame length 2^FRAME_AW samples; buffer address is FRAME_AW+1 bits.
- TRIG_CNT, 3: consecutive active samples needed to trigger capture (1..15).
- HOLD, 4000: hangover, in samples, after the last active sample (< 2^16).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- i_en  in  1  level; low forces IDLE
- i_start  in  1  one-cycle pulse; starts calibration from IDLE
- i_th  in  16  level threshold; latched on i_start
- i_smp_we  in  1  receiver sample strobe
- i_ld  in  16  receiver left sample, signed, valid while i_smp_we is high
- i_active  in  1  receiver activity flag, valid one cycle after i_smp_we
- i_frame_ack  in  1  one-cycle pulse; consumer releases bank o_frame_bank
- o_dc_value  out  16  DC estimate to the receiver
- o_level_th  out  16  threshold to the receiver
- o_wr_en  out  1  buffer write strobe
- o_wr_addr  out  FRAME_AW+1  {bank, index}
- o_wr_data  out  16  DC-removed sample
- o_frame_rdy  out  1  at least one bank is full
- o_frame_bank  out  1  oldest full bank
- o_busy  out  1  state is not IDLE
- o_overrun  out  1  sticky; cleared by i_start

## Operation
- Strobe alignment: s1 is i_smp_we delayed by one clock. Every sample action happens on s1, using i_ld as captured during i_smp_we and the current i_active.
- States: IDLE, CAL, ARMED, CAPTURE.
- IDLE → CAL on i_start while i_en is high. At the same time: o_level_th ← i_th, accumulator and sample counter cleared, o_overrun ← 0.
- CAL: sign-extend each sample and add it into a (16+CAL_LOG2)-bit accumulator. After the 2^CAL_LOG2-th sample, o_dc_value ← accumulator >> CAL_LOG2 (arithmetic shift, truncating) and the state moves to ARMED. i_active is ignored in CAL.
- ARMED: the run counter increments on active samples and clears on inactive ones. When it reaches TRIG_CNT, that sample is written at index 0 of the current bank, the hold counter loads HOLD, and the state moves to CAPTURE.
- ARMED when the current bank is full: the trigger is ignored and the run counter keeps counting, saturating at TRIG_CNT.
- CAPTURE: one write per s1. Index increments. An active sample reloads the hold counter; an inactive one decrements it, saturating at 0.
- Frame end (index wraps from 2^FRAME_AW−1): mark the bank full and toggle the current bank. Then:
  - if the hold counter is 0, go to ARMED with the run counter cleared;
  - else if the new bank is full, set o_overrun and go to ARMED;
  - else stay in CAPTURE at index 0.
- Write data: i_ld − o_dc_value as a 17-bit signed result, saturated to 0x7FFF / 0x8000.
- Handshake:
  - o_frame_rdy = OR of the two full flags.
  - o_frame_bank = the oldest full bank, tracked by a read pointer.
  - i_frame_ack clears full[o_frame_bank] and toggles the read pointer.
  - An ack while o_frame_rdy is low is ignored.
  - If an ack and a frame-end land on the same cycle, both take effect.
- i_en low, from any state, on the next clock:
  - state goes to IDLE;
  - full flags, read pointer and current bank are cleared;
  - o_dc_value, o_level_th and o_overrun are kept.
- i_start outside IDLE is ignored.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- Write latency: o_wr_en, o_wr_addr and o_wr_data are registered and high one cycle after s1, i.e. two clocks after i_smp_we.
- o_dc_value updates on the clock after the last calibration s1. The state is ARMED from that same edge.
- o_frame_rdy rises one clock after the last write of the frame. It falls one clock after an ack that empties the last full bank.
- o_busy is registered and follows the state with one clock of lag.
- Back-to-back i_smp_we pulses spaced at least 3 clocks apart are fully supported.

## Test plan
- Calibration: i_ld held at constant 0x0100, CAL_LOG2=2, start → after 4 samples o_dc_value = 0x0100 and state is ARMED. Then i_ld = 0x0105 → writes carry 0x0005.
- Trigger: active pattern 1,1,0,1,1,1 with TRIG_CNT=3 → the first write is the 6th sample, at address {0, 0}.
- Two frames and ack: FRAME_AW=2, HOLD large, continuous activity → 4 writes to bank 0, then o_frame_rdy=1 with bank 0. The next 4 writes go to bank 1. Ack → o_frame_bank becomes 1.
- Overrun: no acks, continuous activity → after the second frame o_overrun=1, state ARMED, no further writes. Ack bank 0 → trigger succeeds and writes go to bank 0.
- Hangover: HOLD=2, activity stops at index 1 of a 4-sample frame → the frame completes (4 writes), then ARMED with no writes to bank 1.
- Saturation and abort: i_ld = 0x8000 with dc = 0x0010 → data 0x8000. Drop i_en mid-frame → IDLE next clock, o_frame_rdy=0, o_dc_value kept.

Source files
------------

// File: rtl/mic_capture_ctrl.sv
// Capture sequencer for the I2S microphone front end: DC calibration, voice-triggered
// frame capture into a two-bank buffer, and a ready/ack handoff to the consumer.
module mic_capture_ctrl #(
    parameter int CAL_LOG2 = 8,
    parameter int FRAME_AW = 9,
    parameter int TRIG_CNT = 3,
    parameter int HOLD     = 4000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_en,
    input  logic                i_start,
    input  logic [15:0]         i_th,
    input  logic                i_smp_we,
    input  logic [15:0]         i_ld,
    input  logic                i_active,
    input  logic                i_frame_ack,
    output logic [15:0]         o_dc_value,
    output logic [15:0]         o_level_th,
    output logic                o_wr_en,
    output logic [FRAME_AW:0]   o_wr_addr,
    output logic [15:0]         o_wr_data,
    output logic                o_frame_rdy,
    output logic                o_frame_bank,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam int         ACC_W  = 16 + CAL_LOG2;
    localparam logic [3:0] TRIG_C = TRIG_CNT[3:0];
    localparam logic [15:0] HOLD_C = HOLD[15:0];

    typedef enum logic [1:0] {IDLE, CAL, ARMED, CAPTURE} state_t;

    state_t                state;
    logic                  s1;
    logic [15:0]           ld_q;
    logic [ACC_W-1:0]      acc;
    logic [CAL_LOG2-1:0]   cal_cnt;
    logic [3:0]            run_cnt;
    logic [15:0]           hold_cnt;
    logic [FRAME_AW-1:0]   idx;
    logic                  cur_bank;
    logic                  rd_ptr;
    logic [1:0]            full;

    logic [ACC_W-1:0]      acc_sum;
    logic [16:0]           diff;
    logic [15:0]           sat_data;
    logic [3:0]            run_inc;
    logic [15:0]           hold_upd;
    logic                  frame_end;
    logic                  ack_ok;
    logic [1:0]            ack_mask;
    logic [1:0]            set_mask;
    logic [1:0]            full_next;

    always_comb begin
        acc_sum   = acc + {{CAL_LOG2{ld_q[15]}}, ld_q};
        diff      = {ld_q[15], ld_q} - {o_dc_value[15], o_dc_value};
        sat_data  = diff[15:0];
        if (diff[16] != diff[15])
            sat_data = diff[16] ? 16'h8000 : 16'h7FFF;
        run_inc   = (run_cnt == TRIG_C) ? run_cnt : run_cnt + 4'd1;
        hold_upd  = i_active ? HOLD_C : ((hold_cnt == 16'd0) ? 16'd0 : hold_cnt - 16'd1);
        frame_end = (idx == {FRAME_AW{1'b1}});
        // An ack only counts once the consumer has actually been shown a ready bank.
        ack_ok    = i_frame_ack & o_frame_rdy;
        ack_mask  = ack_ok ? (rd_ptr ? 2'b10 : 2'b01) : 2'b00;
        set_mask  = (state == CAPTURE && s1 && frame_end) ? (cur_bank ? 2'b10 : 2'b01) : 2'b00;
        full_next = (full | set_mask) & ~ack_mask;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            s1           <= 1'b0;
            ld_q         <= '0;
            acc          <= '0;
            cal_cnt      <= '0;
            run_cnt      <= '0;
            hold_cnt     <= '0;
            idx          <= '0;
            cur_bank     <= 1'b0;
            rd_ptr       <= 1'b0;
            full         <= '0;
            o_dc_value   <= '0;
            o_level_th   <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_rdy  <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            s1      <= i_smp_we;
            o_wr_en <= 1'b0;
            o_busy  <= (state != IDLE);
            if (i_smp_we)
                ld_q <= i_ld;

            if (!i_en) begin
                state       <= IDLE;
                full        <= '0;
                rd_ptr      <= 1'b0;
                cur_bank    <= 1'b0;
                o_frame_rdy <= 1'b0;
            end else begin
                full        <= full_next;
                // Ready uses the pre-update flags so it rises a clock after the last write lands.
                o_frame_rdy <= |(full & ~ack_mask);
                if (ack_ok)
                    rd_ptr <= ~rd_ptr;

                case (state)
                    IDLE: begin
                        if (i_start) begin
                            state      <= CAL;
                            o_level_th <= i_th;
                            o_overrun  <= 1'b0;
                            acc        <= '0;
                            cal_cnt    <= '0;
                            run_cnt    <= '0;
                            hold_cnt   <= '0;
                            idx        <= '0;
                        end
                    end
                    CAL: begin
                        if (s1) begin
                            acc     <= acc_sum;
                            cal_cnt <= cal_cnt + CAL_LOG2'(1);
                            if (cal_cnt == {CAL_LOG2{1'b1}}) begin
                                o_dc_value <= acc_sum[CAL_LOG2 +: 16];
                                state      <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        if (s1) begin
                            if (!i_active) begin
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_inc;
                                if (run_inc == TRIG_C && !full[cur_bank]) begin
                                    o_wr_en   <= 1'b1;
                                    o_wr_addr <= {cur_bank, {FRAME_AW{1'b0}}};
                                    o_wr_data <= sat_data;
                                    idx       <= FRAME_AW'(1);
                                    hold_cnt  <= HOLD_C;
                                    state     <= CAPTURE;
                                end
                            end
                        end
                    end
                    CAPTURE: begin
                        if (s1) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= {cur_bank, idx};
                            o_wr_data <= sat_data;
                            idx       <= idx + FRAME_AW'(1);
                            hold_cnt  <= hold_upd;
                            if (frame_end) begin
                                cur_bank <= ~cur_bank;
                                if (hold_upd == 16'd0) begin
                                    state   <= ARMED;
                                    run_cnt <= '0;
                                end else if (full[~cur_bank]) begin
                                    o_overrun <= 1'b1;
                                    state     <= ARMED;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_frame_bank = rd_ptr;

endmodule
